// File: rtl/seq_div.sv
// seq_div: iterative restoring divider, one trial subtraction per clock.
// Optional signed support is compiled in with `define DIV_SIGNED_EN.
module seq_div #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         sgn,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         DZ
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef DIV_SIGNED_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  function automatic logic [N-1:0] negate(input logic [N-1:0] x);
    return ~x + {{(N-1){1'b0}}, 1'b1};
  endfunction
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t         state_r, state_nxt_s;
  logic [CW-1:0]  cnt_r, cnt_nxt_s;
  logic [N-1:0]   p_r, p_nxt_s;
  logic [N-1:0]   qw_r, qw_nxt_s;
  logic [N-1:0]   d_r, d_nxt_s;
  logic           busy_r, busy_nxt_s;
  logic           done_r, done_nxt_s;
  logic [N-1:0]   q_r, q_nxt_s;
  logic [N-1:0]   r_r, r_nxt_s;
  logic           dz_r, dz_nxt_s;

  logic [N:0]     p_shift_s;
  logic [N:0]     trial_s;
  logic [N-1:0]   p_step_s;
  logic [N-1:0]   qw_step_s;
  logic [N-1:0]   a_mag_s;
  logic [N-1:0]   b_mag_s;

`ifdef DIV_SIGNED_EN
  logic           neg_q_r, neg_q_nxt_s;
  logic           neg_rem_r, neg_rem_nxt_s;
  logic           neg_q_in_s, neg_rem_in_s;

  // Operand magnitudes and result sign flags captured at acceptance
  always_comb begin
    a_mag_s      = (sgn && A[N-1]) ? negate(A) : A;
    b_mag_s      = (sgn && B[N-1]) ? negate(B) : B;
    neg_q_in_s   = sgn & (A[N-1] ^ B[N-1]);
    neg_rem_in_s = sgn & A[N-1];
  end
`else
  logic sgn_unused_s;
  assign a_mag_s      = A;
  assign b_mag_s      = B;
  assign sgn_unused_s = sgn;
`endif

  // One restoring step: shift in the next dividend bit and try to subtract the divisor
  always_comb begin
    p_shift_s = {p_r, qw_r[N-1]};
    trial_s   = p_shift_s - {1'b0, d_r};
    if (trial_s[N]) begin
      p_step_s  = p_shift_s[N-1:0];
      qw_step_s = {qw_r[N-2:0], 1'b0};
    end else begin
      p_step_s  = trial_s[N-1:0];
      qw_step_s = {qw_r[N-2:0], 1'b1};
    end
  end

  // Next-state and next-register logic for the control FSM and datapath
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    p_nxt_s     = p_r;
    qw_nxt_s    = qw_r;
    d_nxt_s     = d_r;
    busy_nxt_s  = 1'b0;
    done_nxt_s  = 1'b0;
    q_nxt_s     = q_r;
    r_nxt_s     = r_r;
    dz_nxt_s    = dz_r;
`ifdef DIV_SIGNED_EN
    neg_q_nxt_s   = neg_q_r;
    neg_rem_nxt_s = neg_rem_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          p_nxt_s   = {N{1'b0}};
          cnt_nxt_s = {CW{1'b0}};
          qw_nxt_s  = a_mag_s;
          d_nxt_s   = b_mag_s;
          dz_nxt_s  = (B == {N{1'b0}});
`ifdef DIV_SIGNED_EN
          neg_q_nxt_s   = neg_q_in_s;
          neg_rem_nxt_s = neg_rem_in_s;
`endif
          // Zero divisor bypasses the iteration entirely
          if (B == {N{1'b0}}) begin
            state_nxt_s = DONE;
            done_nxt_s  = 1'b1;
            q_nxt_s     = {N{1'b1}};
            r_nxt_s     = A;
          end else begin
            state_nxt_s = RUN;
            busy_nxt_s  = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        p_nxt_s   = p_step_s;
        qw_nxt_s  = qw_step_s;
        cnt_nxt_s = cnt_r + CW'(1);
        if (cnt_r == LAST) begin
`ifdef DIV_SIGNED_EN
          state_nxt_s = FIX;
          busy_nxt_s  = 1'b1;
`else
          state_nxt_s = DONE;
          done_nxt_s  = 1'b1;
          q_nxt_s     = qw_step_s;
          r_nxt_s     = p_step_s;
`endif
        end else begin
          state_nxt_s = RUN;
          busy_nxt_s  = 1'b1;
        end
      end
`ifdef DIV_SIGNED_EN
      FIX: begin
        state_nxt_s = DONE;
        done_nxt_s  = 1'b1;
        q_nxt_s     = neg_q_r   ? negate(qw_r) : qw_r;
        r_nxt_s     = neg_rem_r ? negate(p_r)  : p_r;
      end
`endif
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      p_r     <= {N{1'b0}};
      qw_r    <= {N{1'b0}};
      d_r     <= {N{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      q_r     <= {N{1'b0}};
      r_r     <= {N{1'b0}};
      dz_r    <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      p_r     <= p_nxt_s;
      qw_r    <= qw_nxt_s;
      d_r     <= d_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      q_r     <= q_nxt_s;
      r_r     <= r_nxt_s;
      dz_r    <= dz_nxt_s;
`ifdef DIV_SIGNED_EN
      neg_q_r   <= neg_q_nxt_s;
      neg_rem_r <= neg_rem_nxt_s;
`endif
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign Q    = q_r;
  assign R    = r_r;
  assign DZ   = dz_r;

endmodule

// File: doc/seq_div.md
# seq_div

Iterative restoring divider that completes the datapath's arithmetic set. It reuses the subtract-and-borrow scheme of the combinational subtractor, one trial subtraction per clock. It sits beside the ALU and services DIVU (and DIV when signed support is compiled in). It writes quotient to LO and remainder to HI in the execute stage, and stalls the pipeline while `busy` is high.

## Interface
- `N`, 32, operand/result width in bits (≥2)
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  request; sampled only in IDLE
- `A`  in  N  dividend
- `B`  in  N  divisor
- `sgn`  in  1  1 = signed operation (used only with `DIV_SIGNED_EN`)
- `busy`  out  1  high from the cycle after acceptance until `done`
- `done`  out  1  one-cycle pulse; `Q`/`R` valid from this cycle
- `Q`  out  N  quotient
- `R`  out  N  remainder
- `DZ`  out  1  divide-by-zero flag for the last operation

## Operation
- States:
  - IDLE
  - RUN: iteration counter 0..N-1
  - FIX: present only with `DIV_SIGNED_EN`
  - DONE
- IDLE → RUN on `start`=1. Cycle of acceptance:
  - latch A, B
  - clear partial remainder P (N+1 bits)
  - clear counter
  - `DZ` ← (B==0)
- If B==0, go IDLE → DONE directly, skipping RUN:
  - Q = all ones
  - R = A (unsigned, or signed A)
  - `DZ`=1
- RUN step:
  - P' = {P[N-1:0], Qreg[N-1]}; Qreg shifts left.
  - Trial T = P' − {0,B}, computed in N+1 bits.
  - Borrow out (T[N]=1): keep P', insert quotient bit 0.
  - No borrow: P ← T, insert quotient bit 1.
- After N steps: RUN → DONE, or RUN → FIX with signed support.
- DONE: `done`=1 for exactly one cycle, `busy`=0, then → IDLE.
- `Q`/`R` hold their values until the next accepted operation's DONE.
- `start` while not IDLE is ignored. There is no queueing.
- `start` in the DONE cycle is ignored. The earliest accepted restart is the cycle after `done`.
- `A`/`B` changes after acceptance have no effect.

## Timing
- Reset: state IDLE, `busy`=0, `done`=0, `Q`=0, `R`=0, `DZ`=0, counter=0.
- Reset mid-operation aborts the operation with no `done` pulse. All outputs go to their reset values on the next edge.
- `start` accepted at edge t gives:
  - `busy`=1 in cycles t+1 … t+N (t+N+1 signed build)
  - `done`=1 in cycle t+N+1 (t+N+2 signed build)
- Divide-by-zero: `busy`=0, `done`=1 in cycle t+1 (same in both builds).
- Fixed latency, independent of operand values. No early termination.
- Back-to-back throughput: one operation per N+2 cycles (N+3 signed).

## Configuration
- `DIV_SIGNED_EN` defined:
  - `sgn`=1 takes magnitudes of A and B at acceptance.
  - Unsigned iteration runs as normal.
  - FIX negates Q if sign(A)≠sign(B), and negates R if A<0 (remainder takes the dividend's sign, truncation toward zero).
  - FIX is traversed for every operation, including `sgn`=0, so latency stays fixed.
  - Most-negative ÷ −1: Q = most-negative, R = 0, `DZ`=0.
- `DIV_SIGNED_EN` undefined:
  - `sgn` is ignored, and all operations are unsigned.
  - No FIX state, latency N+1.

## Test plan
- Unsigned divide: N=32, A=100, B=7, `start` at t → `done` at t+33 with Q=14, R=2, `DZ`=0. `busy` is high t+1..t+32.
- Extremes:
  - A=0xFFFFFFFF, B=1 → Q=0xFFFFFFFF, R=0.
  - A=5, B=9 → Q=0, R=5.
  - A=0x80000000, B=0xFFFFFFFF → Q=0, R=0x80000000.
- Divide-by-zero: A=0x1234, B=0 → `done` at t+1, Q=0xFFFFFFFF, R=0x1234, `DZ`=1. A following 20/4 gives `DZ`=0, Q=5, R=0.
- Start handling:
  - `start` pulsed with A=9, B=3 at t+5 during a 100/7 run → ignored, first result 14/2.
  - `start` held high continuously → a new operation is accepted the cycle after each `done`.
- Reset mid-operation: `rst` at t+10 of a 100/7 run → no `done` pulse, Q=R=0, `busy`=0 next cycle. A subsequent 50/5 gives Q=10, R=0.
- Signed build only:
  - `sgn`=1, A=−7, B=2 → Q=−3 (0xFFFFFFFD), R=−1, `done` at t+34.
  - A=0x80000000, B=0xFFFFFFFF → Q=0x80000000, R=0.
